// File: rtl/zsy_bcd_scan_counter.sv
// DIGITS-wide BCD up/down counter with reload/terminal compare and a multiplexed 7-segment scan driver.
// Optional leading-zero blanking is enabled by defining ZSY_LZB_EN.
module zsy_bcd_scan_counter #(
   parameter int unsigned DIGITS   = 4,
   parameter int unsigned SCAN_DIV = 1000
) (
   input  logic                  CP,
   input  logic                  MR,
   input  logic                  EN,
   input  logic                  UP,
   input  logic [4*DIGITS-1:0]   A,
   input  logic [4*DIGITS-1:0]   B,
   output logic [4*DIGITS-1:0]   Q,
   output logic                  TC,
   output logic [6:0]            Y,
   output logic [DIGITS-1:0]     DIG,
   output logic                  DP
);

   localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int unsigned PW = $clog2(SCAN_DIV);
   localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
   localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);

   logic [4*DIGITS-1:0] cnt_q, cnt_d;
   logic                tc_q, tc_d;
   logic [PW-1:0]       pre_q, pre_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [6:0]          seg_q, seg_d;
   logic [DIGITS-1:0]   dig_q, dig_d;

   logic                carry;
   logic [3:0]          digit;
   logic [3:0]          sel;
`ifdef ZSY_LZB_EN
   logic                upper_zero;
   logic                blank;
`endif

   function automatic logic [6:0] decode(input logic [3:0] d);
      case (d)
         4'd0:    decode = 7'h3F;
         4'd1:    decode = 7'h06;
         4'd2:    decode = 7'h5B;
         4'd3:    decode = 7'h4F;
         4'd4:    decode = 7'h66;
         4'd5:    decode = 7'h6D;
         4'd6:    decode = 7'h7C;
         4'd7:    decode = 7'h07;
         4'd8:    decode = 7'h7F;
         4'd9:    decode = 7'h67;
         default: decode = 7'h00;
      endcase
   endfunction

   // Ripple carry/borrow through the digits; non-BCD digits act like 9 (up) or 0 (down).
   always_comb begin
      cnt_d = cnt_q;
      tc_d  = 1'b0;
      carry = 1'b1;
      digit = '0;
      if (EN) begin
         if (cnt_q == B) begin
            cnt_d = A;
            tc_d  = 1'b1;
         end else begin
            for (int unsigned i = 0; i < DIGITS; i++) begin
               digit = cnt_q[4*i +: 4];
               if (carry) begin
                  if (UP) begin
                     if (digit >= 4'd9) begin
                        cnt_d[4*i +: 4] = 4'd0;
                     end else begin
                        cnt_d[4*i +: 4] = digit + 4'd1;
                        carry           = 1'b0;
                     end
                  end else begin
                     if (digit == 4'd0 || digit > 4'd9) begin
                        cnt_d[4*i +: 4] = 4'd9;
                     end else begin
                        cnt_d[4*i +: 4] = digit - 4'd1;
                        carry           = 1'b0;
                     end
                  end
               end
            end
         end
      end
   end

   always_comb begin
      pre_d = pre_q + 1'b1;
      idx_d = idx_q;
      if (pre_q == PRE_LAST) begin
         pre_d = '0;
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end
   end

   always_comb begin
      sel   = '0;
      dig_d = '1;
`ifdef ZSY_LZB_EN
      upper_zero = 1'b1;
      blank      = 1'b0;
`endif
      // Walk from the top digit down so the all-higher-zero flag is available per position.
      for (int unsigned k = 0; k < DIGITS; k++) begin
`ifdef ZSY_LZB_EN
         upper_zero = upper_zero && (cnt_q[4*(DIGITS-1-k) +: 4] == 4'd0);
`endif
         if (IW'(DIGITS - 1 - k) == idx_q) begin
            sel = cnt_q[4*(DIGITS-1-k) +: 4];
`ifdef ZSY_LZB_EN
            blank = upper_zero && (k != DIGITS - 1);
`endif
         end
         dig_d[k] = (IW'(k) != idx_q);
      end
`ifdef ZSY_LZB_EN
      seg_d = blank ? 7'h00 : decode(sel);
`else
      seg_d = decode(sel);
`endif
   end

   always_ff @(posedge CP or posedge MR) begin
      if (MR) begin
         cnt_q <= '0;
         tc_q  <= 1'b0;
         pre_q <= '0;
         idx_q <= '0;
         seg_q <= '0;
         dig_q <= '1;
      end else begin
         cnt_q <= cnt_d;
         tc_q  <= tc_d;
         pre_q <= pre_d;
         idx_q <= idx_d;
         seg_q <= seg_d;
         dig_q <= dig_d;
      end
   end

   assign Q   = cnt_q;
   assign TC  = tc_q;
   assign Y   = seg_q;
   assign DIG = dig_q;
   assign DP  = 1'b1;

endmodule

// File: tb/tb_zsy_bcd_scan_counter.sv
// Randomized bench for zsy_bcd_scan_counter against a decimal-arithmetic reference model.
// Honours ZSY_LZB_EN in the display model when it is defined.
module tb_zsy_bcd_scan_counter;

   localparam int D  = 4;
   localparam int SD = 4;

   logic        CP = 1'b0;
   logic        MR, EN, UP;
   logic [15:0] A, B, Q;
   logic        TC;
   logic [6:0]  Y;
   logic [3:0]  DIG;
   logic        DP;

   zsy_bcd_scan_counter #(.DIGITS(D), .SCAN_DIV(SD)) dut (
      .CP(CP), .MR(MR), .EN(EN), .UP(UP), .A(A), .B(B),
      .Q(Q), .TC(TC), .Y(Y), .DIG(DIG), .DP(DP)
   );

   always #5 CP = ~CP;

   int errors = 0;
   int checks = 0;
   int mq, aval, bval, n;
   bit mtc;
   logic [6:0] segtab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7C, 7'h07, 7'h7F, 7'h67};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int pow10(input int e);
      int r = 1;
      for (int i = 0; i < e; i++) r = r * 10;
      return r;
   endfunction

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      for (int i = 0; i < D; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
      return r;
   endfunction

   // One clock edge: model update from the decimal rules, then compare all outputs.
   task automatic tick();
      int qb, idx, dg;
      logic [6:0] ys;
      logic [3:0] dexp;
      A  = to_bcd(aval);
      B  = to_bcd(bval);
      qb = mq;
      if (EN) begin
         if (mq == bval) begin
            mq  = aval;
            mtc = 1'b1;
         end else begin
            mtc = 1'b0;
            mq  = UP ? (mq + 1) % 10000 : (mq + 9999) % 10000;
         end
      end else begin
         mtc = 1'b0;
      end
      idx = (n / SD) % D;
      n++;
      dg = (qb / pow10(idx)) % 10;
      ys = segtab[dg];
`ifdef ZSY_LZB_EN
      if (idx > 0 && qb < pow10(idx)) ys = 7'h00;
`endif
      dexp      = 4'hF;
      dexp[idx] = 1'b0;
      @(posedge CP);
      #1;
      chk("Q", Q, to_bcd(mq));
      chk("TC", TC, mtc);
      chk("DIG", DIG, dexp);
      chk("Y", Y, ys);
   endtask

   task automatic do_reset();
      MR = 1'b1;
      #1;
      chk("rst_Q", Q, 16'h0000);
      chk("rst_TC", TC, 1'b0);
      chk("rst_DIG", DIG, 4'hF);
      chk("rst_Y", Y, 7'h00);
      chk("rst_DP", DP, 1'b1);
      #1;
      MR  = 1'b0;
      mq  = 0;
      mtc = 1'b0;
      n   = 0;
   endtask

   task automatic load(input int v);
      aval = v;
      bval = mq;
      EN   = 1'b1;
      tick();
   endtask

   task automatic raw_edge(input logic [15:0] a, input logic [15:0] b, input logic up,
                           input logic [15:0] exp, input string tag);
      A  = a;
      B  = b;
      UP = up;
      EN = 1'b1;
      @(posedge CP);
      #1;
      chk(tag, Q, exp);
   endtask

   initial begin
      EN = 1'b0; UP = 1'b1; aval = 0; bval = 0; A = '0; B = '0; MR = 1'b0;
      do_reset();

      // mid-count reset
      EN = 1'b1; UP = 1'b1; bval = 9999;
      repeat (5) tick();
      do_reset();
      repeat (3) tick();

      // count up to terminal 0012 and reload 0000
      do_reset();
      aval = 0; bval = 12; EN = 1'b1; UP = 1'b1;
      repeat (16) tick();

      // down count with reload at 0000, then 1000 -> 0999
      UP = 1'b0;
      load(5);
      aval = 5; bval = 0;
      repeat (8) tick();
      load(1000);
      bval = 5; UP = 1'b0;
      tick();

      // 0999 -> 1000, hold, 1001; 9999 -> 0000
      load(999);
      bval = 9999; UP = 1'b1;
      EN = 1'b1; tick();
      EN = 1'b0; tick();
      EN = 1'b1; tick();
      load(9999);
      bval = 0; UP = 1'b1;
      tick();
      tick();

      // frozen display scans
      load(1234); EN = 1'b0; repeat (20) tick();
      load(7);    EN = 1'b0; repeat (16) tick();
      load(0);    EN = 1'b0; repeat (16) tick();
      load(107);  EN = 1'b0; repeat (16) tick();

      // randomized run
      for (int it = 0; it < 400; it++) begin
         EN = ($urandom_range(0, 3) != 0);
         UP = $urandom_range(0, 1);
         if ($urandom_range(0, 15) == 0) begin
            aval = $urandom_range(0, 9999);
            bval = (mq + $urandom_range(0, 10)) % 10000;
         end
         if ($urandom_range(0, 99) == 0) do_reset();
         tick();
      end

      // non-BCD digits loaded from A
      raw_edge(16'h00A9, to_bcd(mq), 1'b1, 16'h00A9, "ld_00A9");
      raw_edge(16'h0000, 16'h9999, 1'b1, 16'h0100, "inc_00A9");
      raw_edge(16'h00B0, 16'h0100, 1'b0, 16'h00B0, "ld_00B0");
      raw_edge(16'h0000, 16'h1234, 1'b0, 16'h9999, "dec_00B0");
      raw_edge(16'h0A5C, 16'h9999, 1'b1, 16'h0A5C, "ld_0A5C");
      raw_edge(16'h0000, 16'h1111, 1'b1, 16'h0A60, "inc_0A5C");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/zsy_bcd_scan_counter.md
Name: zsy_bcd_scan_counter

Overview:
Parametrised successor to the single-digit counter/comparator/7-segment path. Provides a DIGITS-wide BCD counter with programmable reload value A and terminal value B, and an up/down mode. It also includes a time-multiplexed 7-segment scan driver for a common display with DIGITS positions. It sits between the board clock/switch inputs and the segment/digit pins.

Parameters:
DIGITS, 4, number of BCD digits and digit-select lines (1..8)
SCAN_DIV, 1000, CP cycles each digit stays selected (>=2)

Ports:
CP  input  1  clock, rising edge
MR  input  1  asynchronous active-high reset
EN  input  1  count enable, sampled on CP rising edge
UP  input  1  1 = count up, 0 = count down
A  input  4*DIGITS  reload value, BCD, digit 0 in [3:0]
B  input  4*DIGITS  terminal value, BCD
Q  output  4*DIGITS  current count, registered
TC  output  1  terminal-count pulse, registered
Y  output  7  segments a..g on Y[0]..Y[6], active-high, registered
DIG  output  DIGITS  digit selects, active-low one-hot, registered
DP  output  1  decimal point, constant 1 (off)

Behaviour:
- Reset (MR=1, asynchronous, overrides everything): Q=0, TC=0, prescaler=0, scan index=0, Y=7'h00, DIG=all ones, DP=1.
- Counter, per CP edge with MR=0:
  - EN=0: Q holds and TC=0.
  - EN=1 and Q==B (full 4*DIGITS compare): Q<=A and TC=1 for exactly that cycle.
  - EN=1 and Q!=B and UP=1: BCD increment. A digit at 9 goes to 0 and carries; digits 10..15 are also treated as wrap and go to 0 with carry. All 9s wrap to all 0s.
  - EN=1 and Q!=B and UP=0: BCD decrement. A digit at 0 goes to 9 and borrows; digits 10..15 go to 9 and borrow. All 0s wrap to all 9s.
  - Otherwise TC=0.
- Compare has priority over direction. A and B are not range-checked; non-BCD digits loaded from A are counted per the wrap rules above.
- UP may change on any cycle; it takes effect on the next edge.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1 continuously, independent of EN.
  - On reaching SCAN_DIV-1 it returns to 0 and the scan index advances modulo DIGITS (DIGITS-1 -> 0).
- Display registers, updated every CP edge:
  - DIG <= ~(1<<index).
  - Y <= decode(Q digit[index]).
  - Latency from index/Q change to pins is 1 cycle; the first valid DIG appears 1 edge after MR deasserts.
- Decode, HC4511 style:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7C, 7=07, 8=7F, 9=67.
  - Values 10..15 give 00 (blank).
- DIGITS=1: the index is always 0 and DIG[0] is held at 0 after the first edge.
- MR asserted mid-scan or mid-count: immediate return to reset values. Counting resumes from 0 on the first edge after release.

Optional Feature:
ZSY_LZB_EN:
- Defined: leading-zero blanking. For display index i>0, Y=00 when digit i and every higher digit are 0; digit 0 is never blanked. Q and TC are unaffected.
- Undefined: all digits are always decoded.

Test Plan:
Setup for all scenarios: DIGITS=4, SCAN_DIV=4.
1. MR pulse mid-count while EN=1, UP=1 -> Q=0000, TC=0, DIG=1111, Y=00 immediately (before any edge); after release, Q counts 0001, 0002, ...
2. A=0000, B=0012, UP=1, EN=1 from reset -> Q goes 0000..0012. On the edge after Q=0012, Q=0000 and TC=1 for one cycle. Count 0009->0010 is checked for BCD carry.
3. A=0005, B=0000, UP=0, load via Q==B -> Q goes 0005, 0004, ... 0000, then reload 0005. A separate run with A=1000 checks the decrement 1000->0999.
4. Q=0999, UP=1, B=9999, EN toggles 1,0,1 -> Q goes 1000, holds 1000, then 1001. A run with Q=9999, B=0000 checks the 9999->0000 wrap.
5. Q frozen at 1234 (EN=0) -> DIG cycles 1110, 1101, 1011, 0111, each for 4 cycles, with Y=66, 4F, 5B, 06 respectively, all 1 cycle after the index change.
6. With ZSY_LZB_EN defined and Q=0007 -> Y=07 on digit 0 and 00 on digits 1..3. Q=0000 shows 3F on digit 0 only. Q=0107 shows 3F on digit 1.
